uart_tx: RTL

Byte-serial UART transmitter, 8N1, LSB first, idle-high line. It accepts bytes over a valid/ready handshake into a small FIFO and serialises them back-to-back on `txd_out`. It is the transmit half of the board's UART link and pairs with the team's existing 115200-baud receiver on the 50 MHz system clock.

---
 rtl/uart_tx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, idle-high line.
// Bytes enter a small FIFO over a valid/ready handshake and are serialised
// back-to-back; a queued byte follows the previous stop bit with no idle gap.
module uart_tx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DIV        = CLK_HZ / BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       iCLK,
  input  logic       RST_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd_out,
  output logic       TX_BUSY,
  output logic       TX_END
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CUR_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CUR_W-1:0] r_count;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_txd;
  logic             r_busy;
  logic             r_end;

  logic             w_push;
  logic             w_pop;
  logic             w_tick;
  logic             w_nonempty;

  // Ready comes straight from the registered occupancy; reset holds it low.
  assign tx_ready   = RST_n && (r_count < CUR_W'(FIFO_DEPTH));
  assign w_nonempty = (r_count != '0);
  assign w_tick     = (r_baud == CNT_W'(DIV - 1));
  assign w_push     = tx_valid && tx_ready;
  // The shifter is loaded from idle, or on the last stop-bit cycle when
  // another byte is waiting, so consecutive frames abut.
  assign w_pop      = w_nonempty &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick));

  assign txd_out = r_txd;
  assign TX_BUSY = r_busy;
  assign TX_END  = r_end;

  // FIFO storage write and shifter load (data only, left unreset).
  always_ff @(posedge iCLK) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
    if (w_pop)  r_shift <= r_mem[r_rptr];
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count as is.
  always_ff @(posedge iCLK) begin
    if (!RST_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit.
  always_ff @(posedge iCLK) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      r_end <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_txd  <= ~w_nonempty;
          r_busy <= w_nonempty;
          if (w_nonempty) r_state <= S_START;
        end
        S_START: begin
          if (w_tick) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_txd   <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_txd <= r_shift[r_bit + 3'd1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_baud <= '0;
            r_end  <= 1'b1;
            if (w_nonempty) begin
              r_txd   <= 1'b0;
              r_state <= S_START;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
